mem_access_unit: RTL and testbench

- MEM-stage load/store controller directly upstream of the Mem_Data word RAM (11-bit word address, 1-cycle registered read, word-only write).
- Converts pipeline byte/halfword/word requests into RAM read, write and read-modify-write sequences.
- Extracts and extends load data, and stalls the pipeline until each access completes.

---
 rtl/mem_access_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage load/store controller in front of the Mem_Data word RAM (1-cycle registered read, word-only write).
// Latency : request cycle = 1; rsp_valid in cycle 2 (misaligned), 3 (word store), 4 (load), 5 (sub-word store via RMW).
// Backpr. : stall = req_valid & (state != RESP); the pipeline holds req_* stable until the RESP cycle releases it.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   req_valid/we/size/signed  pipeline request (size 00 byte, 01 half, 10 word, 11 illegal)
//   req_addr, req_wdata       byte address, right-justified store data
//   stall                     pipeline freeze
//   rsp_valid, rsp_rdata      one-cycle completion pulse, extended load data (0 for stores/errors)
//   misalign_err              pulses with rsp_valid on a misaligned/illegal request
//   mem_addr/read/write/wdata RAM command side; mem_rdata RAM read data (valid the cycle after mem_read)
//
// Build option: MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word and size 11 return an error response with no RAM access
//   undefined -> misalign_err tied low, addresses aligned down to the access size, size 11 treated as word

module mem_access_unit #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t state;
    state_t state_nxt;

    // Latched request fields
    logic        lat_we;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        lat_err;
`endif

    // Output registers
    logic [31:0]       rdata_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;

    // Address bits above the RAM index alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // ------------------------------------------------------------------
    // Request decode: effective size, lane offset and misalignment
    // ------------------------------------------------------------------
    logic [1:0] req_eff_size;
    logic [1:0] req_off;
    logic       req_mis;

    always_comb begin
        req_eff_size = req_size;
        req_off      = req_addr[1:0];
        req_mis      = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (req_size)
            SZ_HALF: req_mis = req_addr[0];
            SZ_WORD: req_mis = |req_addr[1:0];
            SZ_ILL:  req_mis = 1'b1;
            default: req_mis = 1'b0;
        endcase
`else
        // No trapping: illegal size behaves as a word, and the offset is
        // forced down to the natural alignment of the access.
        if (req_size == SZ_ILL) begin
            req_eff_size = SZ_WORD;
        end
        case (req_eff_size)
            SZ_HALF: req_off = {req_addr[1], 1'b0};
            SZ_WORD: req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase
`endif
    end

    logic req_word_store;
    assign req_word_store = req_we && (req_eff_size == SZ_WORD);

    // ------------------------------------------------------------------
    // Load extraction and store merge, both working on mem_rdata in RD_WAIT
    // ------------------------------------------------------------------
    logic [4:0]  lane_sh;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic [31:0] st_mask;
    logic [31:0] st_data;
    logic [31:0] st_merge;

    assign lane_sh  = {lat_off, 3'b000};
    assign ld_shift = mem_rdata >> lane_sh;

    always_comb begin
        ld_ext = mem_rdata;
        case (lat_size)
            SZ_BYTE: ld_ext = {{24{lat_signed & ld_shift[7]}},  ld_shift[7:0]};
            SZ_HALF: ld_ext = {{16{lat_signed & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        st_mask = 32'h0000_0000;
        st_data = 32'h0000_0000;
        case (lat_size)
            SZ_BYTE: begin
                st_mask = 32'h0000_00FF << lane_sh;
                st_data = (lat_wdata & 32'h0000_00FF) << lane_sh;
            end
            SZ_HALF: begin
                st_mask = 32'h0000_FFFF << lane_sh;
                st_data = (lat_wdata & 32'h0000_FFFF) << lane_sh;
            end
            default: begin
                st_mask = 32'hFFFF_FFFF;
                st_data = lat_wdata;
            end
        endcase
        // Keep the untouched lanes from the word just read.
        st_merge = (mem_rdata & ~st_mask) | st_data;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_mis) begin
                        state_nxt = RESP;
                    end else if (req_word_store) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = lat_we ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_off    <= 2'b00;
            lat_wdata  <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            lat_err    <= 1'b0;
`endif
            rdata_q    <= 32'h0;
            wdata_q    <= 32'h0;
            addr_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_signed <= req_signed;
                        lat_size   <= req_eff_size;
                        lat_off    <= req_off;
                        lat_wdata  <= req_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
                        lat_err    <= req_mis;
`endif
                        // Cleared here so stores and errors answer with 0.
                        rdata_q    <= 32'h0;
                        // mem_addr/mem_wdata only move when the RAM is used.
                        if (!req_mis) begin
                            addr_q <= req_addr[ADDR_W+1:2];
                        end
                        if (!req_mis && req_word_store) begin
                            wdata_q <= req_wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_we) begin
                        wdata_q <= st_merge;
                    end else begin
                        rdata_q <= ld_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; strobes are gated by rst so the reset edge never hits the RAM
    // ------------------------------------------------------------------
    assign mem_read  = rst && (state == RD);
    assign mem_write = rst && (state == WR);
    assign stall     = rst && req_valid && (state != RESP);
    assign rsp_valid = rst && (state == RESP);
    assign rsp_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_err = rsp_valid && lat_err;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign_err;
    logic [10:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.ADDR_W(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .misalign_err (misalign_err),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word RAM: registered read, word write.
    logic [31:0] ram [0:2047];
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= ram[mem_addr];
        if (mem_write) ram[mem_addr] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        logic [10:0] waddr;
        logic [31:0] wval;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                                input logic [31:0] rdata, input logic err, input int nrd,
                                input int nwr, input logic [10:0] waddr, input logic [31:0] wval);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.rdata = rdata; v.err = err; v.nrd = nrd; v.nwr = nwr;
        v.waddr = waddr; v.wval = wval;
        return v;
    endfunction

    // Present one request and follow it to its response, then compare.
    task automatic run_vec(input string tag, input vec_t v);
        int          lat;
        int          nrd;
        int          nwr;
        logic [10:0] waddr;
        logic [31:0] wval;
        logic [31:0] rdata;
        logic        err;
        logic        stall_ok;
        lat = 0; nrd = 0; nwr = 0; waddr = '0; wval = '0; rdata = '0; err = 1'b0; stall_ok = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            #1;
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                waddr = mem_addr;
                wval  = mem_wdata;
            end
            if (rsp_valid) begin
                lat   = cyc;
                rdata = rsp_rdata;
                err   = misalign_err;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check({tag, " latency"},     lat,      v.lat);
        check({tag, " rsp_rdata"},   rdata,    v.rdata);
        check({tag, " misalign"},    {31'b0, err}, {31'b0, v.err});
        check({tag, " mem_reads"},   nrd,      v.nrd);
        check({tag, " mem_writes"},  nwr,      v.nwr);
        check({tag, " stall_shape"}, {31'b0, stall_ok}, 32'd1);
        if (v.nwr != 0) begin
            check({tag, " write_addr"}, {21'b0, waddr}, {21'b0, v.waddr});
            check({tag, " write_data"}, wval, v.wval);
        end
    endtask

    vec_t vt[18];

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        req_wdata  = 32'hDEADBEEF;

        //              we  size  sgn addr          wdata         lat rdata         err rd wr waddr wval
        vt[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 3, 32'h0,        1'b0, 0, 1, 11'd4, 32'hDEADBEEF);
        vt[1]  = mk(1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        4, 32'hFFFFFFDE, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[2]  = mk(1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        4, 32'h0000BEEF, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[3]  = mk(1'b0, 2'b10, 1'b0, 32'h2010, 32'h0,        4, 32'hDEADBEEF, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[4]  = mk(1'b1, 2'b00, 1'b0, 32'h11,   32'h55,       5, 32'h0,        1'b0, 1, 1, 11'd4, 32'hDEAD55EF);
        vt[5]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        4, 32'hDEAD55EF, 1'b0, 1, 0, 11'd0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        vt[6]  = mk(1'b0, 2'b10, 1'b0, 32'h12,   32'h0,        2, 32'h0,        1'b1, 0, 0, 11'd0, 32'h0);
`else
        vt[6]  = mk(1'b0, 2'b10, 1'b0, 32'h12,   32'h0,        4, 32'hDEAD55EF, 1'b0, 1, 0, 11'd0, 32'h0);
`endif
        vt[7]  = mk(1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        4, 32'hFFFFDEAD, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[8]  = mk(1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        4, 32'h000000EF, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[9]  = mk(1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        4, 32'h00000055, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[10] = mk(1'b1, 2'b10, 1'b0, 32'h20,   32'h11223344, 3, 32'h0,        1'b0, 0, 1, 11'd8, 32'h11223344);
        vt[11] = mk(1'b1, 2'b01, 1'b0, 32'h22,   32'hFFFFABCD, 5, 32'h0,        1'b0, 1, 1, 11'd8, 32'hABCD3344);
        vt[12] = mk(1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        4, 32'hFFFFABCD, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[13] = mk(1'b1, 2'b00, 1'b0, 32'h20,   32'hAAAAAA99, 5, 32'h0,        1'b0, 1, 1, 11'd8, 32'hABCD3399);
        vt[14] = mk(1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        4, 32'hABCD3399, 1'b0, 1, 0, 11'd0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        vt[15] = mk(1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        2, 32'h0,        1'b1, 0, 0, 11'd0, 32'h0);
        vt[16] = mk(1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        2, 32'h0,        1'b1, 0, 0, 11'd0, 32'h0);
        vt[17] = mk(1'b1, 2'b10, 1'b0, 32'h32,   32'h01020304, 2, 32'h0,        1'b1, 0, 0, 11'd0, 32'h0);
`else
        vt[15] = mk(1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        4, 32'hDEAD55EF, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[16] = mk(1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        4, 32'h000055EF, 1'b0, 1, 0, 11'd0, 32'h0);
        vt[17] = mk(1'b1, 2'b10, 1'b0, 32'h32,   32'h01020304, 3, 32'h0,        1'b0, 0, 1, 11'd12, 32'h01020304);
`endif

        // Reset held for two cycles with a request pending.
        @(negedge clk); #1;
        check("rst_c1 stall",     {31'b0, stall},     32'd0);
        check("rst_c1 mem_read",  {31'b0, mem_read},  32'd0);
        check("rst_c1 mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_c1 rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check("rst_c2 stall",     {31'b0, stall},     32'd0);
        check("rst_c2 mem_read",  {31'b0, mem_read},  32'd0);
        check("rst_c2 mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_c2 rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_c2 rsp_rdata", rsp_rdata, 32'd0);
        check("rst_c2 misalign",  {31'b0, misalign_err}, 32'd0);
        check("rst_c2 mem_addr",  {21'b0, mem_addr}, 32'd0);
        check("rst_c2 mem_wdata", mem_wdata, 32'd0);
        req_valid = 1'b0;
        rst       = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Half store interrupted by reset during the RD_WAIT cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_addr   = 32'h12;
        req_wdata  = 32'h1234;
        #1;
        check("rmw_rst idle stall", {31'b0, stall}, 32'd1);
        @(negedge clk); #1;
        check("rmw_rst rd mem_read", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmw_rst wait mem_write", {31'b0, mem_write}, 32'd0);
        check("rmw_rst wait stall",     {31'b0, stall},     32'd0);
        @(negedge clk); #1;
        check("rmw_rst after mem_write", {31'b0, mem_write}, 32'd0);
        check("rmw_rst after rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rmw_rst after mem_addr",  {21'b0, mem_addr}, 32'd0);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk); #1;
        check("rmw_rst rel mem_write", {31'b0, mem_write}, 32'd0);
        check("rmw_rst ram word4", ram[4], 32'hDEAD55EF);
        run_vec("post_rst_load",
                mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4, 32'hDEAD55EF, 1'b0, 1, 0, 11'd0, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
